// File: rtl/ram_pkg.sv
// ram_pkg: shared clear-FSM states, byte-merge helper and port-slice constants for sync_ram_mwnr
package ram_pkg;
  localparam int BYTE_W = 8;
  localparam int MAX_DW = 512;
  localparam int MAX_BE = MAX_DW / BYTE_W;
  typedef enum logic {SWEEP, READY} sweep_state_e;
  function automatic logic [MAX_DW-1:0] merge_bytes(input logic [MAX_DW-1:0] old_v,
                                                    input logic [MAX_DW-1:0] new_v,
                                                    input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] res;
    res = old_v;
    for (int b = 0; b < MAX_BE; b++)
      if (be[b]) res[b*BYTE_W +: BYTE_W] = new_v[b*BYTE_W +: BYTE_W];
    return res;
  endfunction
endpackage

// File: rtl/sync_ram_mwnr_sweep.sv
// sync_ram_mwnr_sweep: clear sequencer that walks every entry after reset or a clr request
module sync_ram_mwnr_sweep
  import ram_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DEPTH  = 1 << AWIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              ready,
  output logic              sweep_we,
  output logic [AWIDTH-1:0] sweep_addr
);
  sweep_state_e      state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              last;
  assign last       = cnt_q == AWIDTH'(DEPTH - 1);
  assign ready      = state_q == READY;
  assign sweep_we   = state_q == SWEEP;
  assign sweep_addr = cnt_q;
  // clr restarts the walk from entry 0 in either state
  always_comb begin
    state_d = state_q == SWEEP ? ((!clr && last) ? READY : SWEEP) : (clr ? SWEEP : READY);
    cnt_d   = (clr || state_q == READY) ? '0 : cnt_q + 1'b1;
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SWEEP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: rtl/sync_ram_mwnr.sv
// sync_ram_mwnr: NW-write/NR-read RAM with byte enables and clear sweep; SYNC_RAM_MWNR_BYPASS_EN selects write-first reads
module sync_ram_mwnr
  import ram_pkg::*;
#(
  parameter int               DWIDTH     = 32,
  parameter int               AWIDTH     = 5,
  parameter int               DEPTH      = 1 << AWIDTH,
  parameter int               NW         = 1,
  parameter int               NR         = 2,
  parameter bit               SYNC_READ  = 1,
  parameter logic [DWIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  output logic                       ready,
  input  logic [NW-1:0]              we,
  input  logic [NW*DWIDTH/8-1:0]     wbe,
  input  logic [NW*AWIDTH-1:0]       waddr,
  input  logic [NW*DWIDTH-1:0]       wdata,
  input  logic [NR-1:0]              re,
  input  logic [NR*AWIDTH-1:0]       raddr,
  output logic [NR*DWIDTH-1:0]       rdata
);
  localparam int NB = DWIDTH / BYTE_W;
  logic              sweep_we;
  logic [AWIDTH-1:0] sweep_addr;
  logic [NW-1:0]     wen;
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [DWIDTH-1:0] rd_val [NR];

  sync_ram_mwnr_sweep #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_sweep (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .ready     (ready),
    .sweep_we  (sweep_we),
    .sweep_addr(sweep_addr)
  );

  assign wen = we & {NW{ready & ~clr}};

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic [DWIDTH-1:0] mem_d;
    // later ports merge over earlier ones so the highest index wins per byte
    always_comb begin
      mem_d = mem[i];
      for (int p = 0; p < NW; p++)
        if (wen[p] && waddr[p*AWIDTH +: AWIDTH] == AWIDTH'(i))
          mem_d = DWIDTH'(merge_bytes(MAX_DW'(mem_d), MAX_DW'(wdata[p*DWIDTH +: DWIDTH]), MAX_BE'(wbe[p*NB +: NB])));
      if (sweep_we && sweep_addr == AWIDTH'(i)) mem_d = INIT_VALUE;
    end
    // array storage carries no reset; the sweep defines its content
    always_ff @(posedge clk) mem[i] <= mem_d;
  end

  // read value per port: 0 out of range, INIT_VALUE while sweeping, optionally forwarded write data
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      rd_val[r] = '0;
      if (int'(raddr[r*AWIDTH +: AWIDTH]) < DEPTH) begin
        rd_val[r] = ready ? mem[raddr[r*AWIDTH +: AWIDTH]] : INIT_VALUE;
`ifdef SYNC_RAM_MWNR_BYPASS_EN
        for (int p = 0; p < NW; p++)
          if (wen[p] && waddr[p*AWIDTH +: AWIDTH] == raddr[r*AWIDTH +: AWIDTH])
            rd_val[r] = DWIDTH'(merge_bytes(MAX_DW'(rd_val[r]), MAX_DW'(wdata[p*DWIDTH +: DWIDTH]), MAX_BE'(wbe[p*NB +: NB])));
`endif
      end
    end
  end

  if (SYNC_READ) begin : g_sync
    logic [DWIDTH-1:0] rdata_q [NR];
    // registered read, updated only when the port is enabled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int r = 0; r < NR; r++) rdata_q[r] <= '0;
      end else begin
        for (int r = 0; r < NR; r++) if (re[r]) rdata_q[r] <= rd_val[r];
      end
    end
    for (genvar r = 0; r < NR; r++) begin : g_out
      assign rdata[r*DWIDTH +: DWIDTH] = rdata_q[r];
    end
  end else begin : g_async
    logic unused_re;
    assign unused_re = ^re;
    for (genvar r = 0; r < NR; r++) begin : g_out
      assign rdata[r*DWIDTH +: DWIDTH] = rd_val[r];
    end
  end
endmodule

// File: doc/sync_ram_mwnr.md
# sync_ram_mwnr

Parametrised multi-port RAM: NW synchronous write ports with byte enables, NR read ports (registered or asynchronous), and a built-in clear sequencer that fills every entry with INIT_VALUE after reset or on request. It replaces ad-hoc single- and dual-port memory instances in register files, caches and scratchpads where more than two ports are needed or a known power-up content is required without a memory image file.

## Interface
- DWIDTH, 32, data width; multiple of 8
- AWIDTH, 5, address width
- DEPTH, 1<<AWIDTH, number of entries; 2 ≤ DEPTH ≤ 2^AWIDTH
- NW, 1, write ports, 1..4
- NR, 2, read ports, 1..8
- SYNC_READ, 1, 1 = registered read, 0 = asynchronous read
- INIT_VALUE, 0, DWIDTH-bit value written to every entry by the sweep
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clr  in  1  single-cycle request to re-run the clear sweep
- ready  out  1  high when the sweep is done and the array is usable
- we  in  NW  per-port write enable
- wbe  in  NW*DWIDTH/8  per-port byte enables; port p occupies bits [p*DWIDTH/8 +: DWIDTH/8]
- waddr  in  NW*AWIDTH  per-port write address, packed the same way
- wdata  in  NW*DWIDTH  per-port write data
- re  in  NR  per-port read enable; used only when SYNC_READ=1
- raddr  in  NR*AWIDTH  per-port read address
- rdata  out  NR*DWIDTH  per-port read data

## Operation
- Clear FSM states: SWEEP and READY.
- Reset:
  - state=SWEEP, sweep counter=0, ready=0.
  - Registered rdata=0.
  - Array contents are undefined until the sweep finishes.
- SWEEP:
  - Each cycle, mem[cnt] <= INIT_VALUE and cnt increments.
  - At the edge where cnt==DEPTH-1, go to READY and set ready=1.
  - Port writes are dropped.
  - Reads return INIT_VALUE. For SYNC_READ=1 this applies only when re=1; otherwise rdata holds.
- READY, clr=1: at the next edge go to SWEEP with cnt=0 and ready=0. Writes presented in that same cycle are dropped.
- SWEEP, clr=1: cnt restarts at 0.
- Writes: mem[waddr_p] byte b <= wdata_p byte b when we_p & wbe_p[b] & ready.
- Writes to the same address and byte from several ports: the highest port index wins.
- Writes with waddr ≥ DEPTH are dropped.
- Reads with raddr ≥ DEPTH return 0.
- Reset mid-sweep restarts from cnt=0. Reset never changes array contents directly.

## Timing
- ready rises DEPTH rising edges after rst_n deasserts, and again DEPTH edges after a clr edge.
- SYNC_READ=1:
  - rdata_p is registered when re_p=1, giving 1-cycle latency. It holds when re_p=0.
  - Same-cycle write to the read address returns the old data (read-first), unless bypass is compiled in.
- SYNC_READ=0: rdata_p = mem[raddr_p] combinationally, 0-cycle latency. A write becomes visible after the edge.
- Writes commit on the edge at which we_p is sampled, with no write latency beyond that edge.

## Configuration
- SYNC_RAM_MWNR_BYPASS_EN defined: reads become write-first.
  - A read of an address being written in the same cycle (ready=1, any port) sees the new bytes wherever wbe is set. Other bytes come from the array.
  - Multi-writer priority is the same as for the array: the highest port index wins.
  - For SYNC_READ=1 the merged value is registered. For SYNC_READ=0 it is driven combinationally.
- Not defined: no forwarding. Reads are read-first (sync) or pre-write (async), and no wdata→rdata path exists.

## Structure
- Package ram_pkg holds:
  - the clear-FSM state enum (SWEEP, READY);
  - a byte-merge function merge_bytes(old, new, be);
  - the port-slice helper constants.
- Sub-module sync_ram_mwnr_sweep: the clear FSM and counter. It outputs ready, sweep_we and sweep_addr, and the top module muxes these into the array write path.
- The array, write-priority resolution and read ports stay in the top module.

## Test plan
- Reset with DEPTH=32, INIT_VALUE=32'hDEADBEEF: ready is 0 for 32 edges, then 1. Reading all 32 addresses returns 32'hDEADBEEF.
- Byte-enable write of 32'h11223344 with wbe=4'b0101 to address 3 (init value 0): a read 1 cycle later returns 32'h00220044.
- NW=2, both ports write address 7 (port0 32'hAAAAAAAA, port1 32'h55555555, wbe all ones): a later read returns 32'h55555555.
- Write 32'h12345678 to address 4 with a simultaneous read of address 4:
  - with SYNC_RAM_MWNR_BYPASS_EN, returns 32'h12345678 next cycle;
  - without it, returns the old value next cycle, then 32'h12345678.
- Assert clr for one cycle together with a write to address 2:
  - ready drops for 32 edges;
  - the write is lost;
  - address 2 then reads INIT_VALUE.
- Pulse rst_n low at cnt=10 of the sweep: ready stays 0 for a full 32 edges after release, and every entry reads INIT_VALUE.
